// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: issues the fetch PC stream under a
// credit check, buffers returned instructions with their PCs, and flushes on redirect.
`ifndef LEN_MEM_ADDR
`define LEN_MEM_ADDR 32
`endif
`ifndef LEN_INST
`define LEN_INST 32
`endif

module inst_queue #(
    parameter int DEPTH     = 4,
    parameter int LOG_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [`LEN_MEM_ADDR-1:0] redirect_pc,
    output logic                     f_order,
    output logic [`LEN_MEM_ADDR-1:0] f_pc,
    input  logic                     f_accepted,
    input  logic                     f_done,
    input  logic [`LEN_INST-1:0]     f_inst,
    output logic                     d_valid,
    output logic [`LEN_INST-1:0]     d_inst,
    output logic [`LEN_MEM_ADDR-1:0] d_pc,
    input  logic                     d_ready
);
    localparam int AW = `LEN_MEM_ADDR;
    localparam int IW = `LEN_INST;
    localparam int CW = LOG_DEPTH + 1;

    logic [AW-1:0]        fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]        tail_pc_q, tail_pc_d;
    logic [LOG_DEPTH-1:0] head_q, head_d;
    logic [LOG_DEPTH-1:0] tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic [CW-1:0]        stale_q, stale_d;
    logic [AW-1:0]        pc_mem_q   [DEPTH];
    logic [IW-1:0]        inst_mem_q [DEPTH];

    logic [CW:0] credits_used;
    logic        accept;
    logic        push;
    logic        pop;

    // Queued plus in-flight entries are the credits; this guarantees a slot for every return.
    assign credits_used = {1'b0, count_q} + {1'b0, inflight_q};
    assign f_order      = ~rst & ~redirect & (credits_used < (CW+1)'(DEPTH));
    assign f_pc         = rst ? '0 : fetch_pc_q;
    assign d_valid      = ~rst & (count_q != '0);
    assign d_inst       = inst_mem_q[head_q];
    assign d_pc         = pc_mem_q[head_q];

    assign accept = f_order & f_accepted;
    assign pop    = d_valid & d_ready & ~redirect;
    assign push   = ~rst & ~redirect & f_done & (stale_q == '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tail_pc_d  = tail_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        stale_d    = stale_q;
        inflight_d = inflight_q + CW'(accept) - CW'(f_done);

        if (redirect) begin
            // Everything still in flight belongs to the old path and must be discarded.
            fetch_pc_d = redirect_pc;
            tail_pc_d  = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            stale_d    = inflight_q - CW'(f_done);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + AW'(4);
            end
            if (f_done && (stale_q != '0)) begin
                stale_d = stale_q - CW'(1);
            end
            if (push) begin
                tail_d    = tail_q + LOG_DEPTH'(1);
                tail_pc_d = tail_pc_q + AW'(4);
            end
            if (pop) begin
                head_d = head_q + LOG_DEPTH'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= '0;
            tail_pc_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            stale_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tail_pc_q  <= tail_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q]   <= tail_pc_q;
            inst_mem_q[tail_q] <= f_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !pop) begin
            assert (count_q != CW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a 2-cycle fetch model feeds the DUT while per-cycle
// vectors check the fetch handshake and the decode-side head entry.
`ifndef LEN_MEM_ADDR
`define LEN_MEM_ADDR 32
`endif
`ifndef LEN_INST
`define LEN_INST 32
`endif

module tb_inst_queue;
    localparam int AW = `LEN_MEM_ADDR;
    localparam int IW = `LEN_INST;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          f_order;
    logic [AW-1:0] f_pc;
    logic          f_accepted;
    logic          f_done;
    logic [IW-1:0] f_inst;
    logic          d_valid;
    logic [IW-1:0] d_inst;
    logic [AW-1:0] d_pc;
    logic          d_ready;

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(4), .LOG_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .f_order    (f_order),
        .f_pc       (f_pc),
        .f_accepted (f_accepted),
        .f_done     (f_done),
        .f_inst     (f_inst),
        .d_valid    (d_valid),
        .d_inst     (d_inst),
        .d_pc       (d_pc),
        .d_ready    (d_ready)
    );

    typedef struct {
        logic          rst;
        logic          rd;
        logic [AW-1:0] rpc;
        logic          acc;
        logic          rdy;
        logic          e_ord;
        logic [AW-1:0] e_fpc;
        logic          e_dv;
        logic [AW-1:0] e_dpc;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // Fetch pipeline model: accept in N, done in N+2.
    logic          v1 = 1'b0;
    logic          v2 = 1'b0;
    logic [AW-1:0] pc1 = '0;
    logic [AW-1:0] pc2 = '0;

    function automatic logic [IW-1:0] imem(input logic [AW-1:0] pc);
        logic [31:0] w;
        w = {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
        return IW'(w);
    endfunction

    function automatic vec_t mk(input int r, input int rd, input longint rpc, input int acc,
                                input int rdy, input int eo, input longint efpc,
                                input int edv, input longint edpc);
        vec_t v;
        v.rst   = (r != 0);
        v.rd    = (rd != 0);
        v.rpc   = AW'(rpc);
        v.acc   = (acc != 0);
        v.rdy   = (rdy != 0);
        v.e_ord = (eo != 0);
        v.e_fpc = AW'(efpc);
        v.e_dv  = (edv != 0);
        v.e_dpc = AW'(edpc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic          acc_s;
        logic [AW-1:0] pc_s;
        rst         = v.rst;
        redirect    = v.rd;
        redirect_pc = v.rpc;
        f_accepted  = v.acc;
        d_ready     = v.rdy;
        @(negedge clk);
        chk({tag, " f_order"}, 64'(f_order), 64'(v.e_ord));
        chk({tag, " f_pc"}, 64'(f_pc), 64'(v.e_fpc));
        chk({tag, " d_valid"}, 64'(d_valid), 64'(v.e_dv));
        if (v.e_dv) begin
            chk({tag, " d_pc"}, 64'(d_pc), 64'(v.e_dpc));
            chk({tag, " d_inst"}, 64'(d_inst), 64'(imem(v.e_dpc)));
        end
        acc_s = f_order & f_accepted;
        pc_s  = f_pc;
        @(posedge clk);
        #1;
        pc2    = pc1;
        v2     = v1;
        v1     = acc_s;
        pc1    = pc_s;
        f_done = v2;
        f_inst = v2 ? imem(pc2) : '0;
    endtask

    task automatic cyc(input string tag, input int r, input int rd, input longint rpc,
                       input int acc, input int rdy, input int eo, input longint efpc,
                       input int edv, input longint edpc);
        apply(mk(r, rd, rpc, acc, rdy, eo, efpc, edv, edpc), tag);
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        f_accepted  = 1'b0;
        d_ready     = 1'b0;
        f_done      = 1'b0;
        f_inst      = '0;

        // Streaming from reset with decode always ready.
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0));
        for (int c = 0; c < 8; c++)
            tbl.push_back(mk(0, 0, 0, 1, 1, 1, 4 * c, (c >= 3) ? 1 : 0, 4 * (c - 3)));

        // Decode stalled: four credits, then resume when d_ready rises in cycle 10.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 4,  0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 8,  0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 12, 1, 0));
        for (int c = 4; c < 10; c++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 16, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 16, 1, 4));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 20, 1, 8));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 24, 1, 12));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 28, 1, 16));

        // Redirect to 0x100 in cycle 5 with two queued and two in flight.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 1, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 0, 1, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 0, 1, 4,     0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 0, 1, 8,     0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 0, 1, 12,    1, 0));
        tbl.push_back(mk(0, 1, 'h100, 1, 1, 0, 16,    1, 0));
        tbl.push_back(mk(0, 0, 0,     1, 1, 1, 'h100, 0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 1, 1, 'h104, 0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 1, 1, 'h108, 0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 1, 1, 'h10c, 1, 'h100));
        tbl.push_back(mk(0, 0, 0,     1, 1, 1, 'h110, 1, 'h104));
        tbl.push_back(mk(0, 0, 0,     1, 1, 1, 'h114, 1, 'h108));

        // Fetch refuses PC 8 for three cycles.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 4,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 8,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 8,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 8,  1, 4));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 8,  0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 12, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 16, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 20, 1, 8));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 24, 1, 12));

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Redirect coinciding with f_done and a ready head.
        for (int i = 0; i < 3; i++) cyc("rr_rst", 1, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) cyc($sformatf("rr_c%0d", c), 0, 0, 0, 1, 1, 1, 4 * c, (c == 3) ? 1 : 0, 0);
        cyc("rr_c4",  0, 1, 'h200, 1, 1, 0, 16,    1, 4);
        cyc("rr_c5",  0, 0, 0,     1, 1, 1, 'h200, 0, 0);
        cyc("rr_c6",  0, 0, 0,     1, 1, 1, 'h204, 0, 0);
        cyc("rr_c7",  0, 0, 0,     1, 1, 1, 'h208, 0, 0);
        cyc("rr_c8",  0, 0, 0,     1, 1, 1, 'h20c, 1, 'h200);
        cyc("rr_c9",  0, 0, 0,     1, 1, 1, 'h210, 1, 'h204);

        // Back-to-back redirects: the second one re-derives the stale count.
        cyc("rr_c10", 0, 1, 'h400, 1, 1, 0, 'h214, 1, 'h208);
        cyc("rr_c11", 0, 1, 'h300, 1, 1, 0, 'h400, 0, 0);
        cyc("rr_c12", 0, 0, 0,     1, 1, 1, 'h300, 0, 0);
        cyc("rr_c13", 0, 0, 0,     1, 1, 1, 'h304, 0, 0);
        cyc("rr_c14", 0, 0, 0,     1, 1, 1, 'h308, 0, 0);
        cyc("rr_c15", 0, 0, 0,     1, 1, 1, 'h30c, 1, 'h300);

        // PC wraps past the top of the address space.
        cyc("wr_c16", 0, 1, 'hFFFF_FFF8, 1, 1, 0, 'h310,       1, 'h304);
        cyc("wr_c17", 0, 0, 0,           1, 1, 1, 'hFFFF_FFF8, 0, 0);
        cyc("wr_c18", 0, 0, 0,           1, 1, 1, 'hFFFF_FFFC, 0, 0);
        cyc("wr_c19", 0, 0, 0,           1, 1, 1, 0,           0, 0);
        cyc("wr_c20", 0, 0, 0,           1, 1, 1, 4,           1, 'hFFFF_FFF8);
        cyc("wr_c21", 0, 0, 0,           1, 1, 1, 8,           1, 'hFFFF_FFFC);
        cyc("wr_c22", 0, 0, 0,           1, 1, 1, 12,          1, 0);

        // Reset mid-stream: late dones arrive during reset and must vanish.
        for (int i = 0; i < 3; i++) cyc($sformatf("mr_rst%0d", i), 1, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc("mr_c0", 0, 0, 0, 1, 1, 1, 0,  0, 0);
        cyc("mr_c1", 0, 0, 0, 1, 1, 1, 4,  0, 0);
        cyc("mr_c2", 0, 0, 0, 1, 1, 1, 8,  0, 0);
        cyc("mr_c3", 0, 0, 0, 1, 1, 1, 12, 1, 0);
        cyc("mr_c4", 0, 0, 0, 1, 1, 1, 16, 1, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
